// File: rtl/sprite_collision_matrix_if.sv
// Register-bus bundle for the sprite collision matrix: word-addressed
// read/write strobes, registered read data and the collision interrupt.
interface sprite_collision_matrix_if;
   logic [7:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, read, write, writedata, input readdata, irq);
   modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/sprite_collision_matrix.sv
// Per-frame sprite collision matrix: records which priority levels overlap
// which, snapshots the matrix at each frame boundary and exposes it on a bus.
module sprite_collision_matrix #(
   parameter int N_LAYERS = 4,
   parameter int LEVEL_W  = 5,
   parameter int ID_W     = 9,
   parameter int ENTRY_W  = LEVEL_W + ID_W + 9
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         new_pixel,
   input  logic                         new_frame,
   input  logic [N_LAYERS*ENTRY_W-1:0]  h_in,
   sprite_collision_matrix_if.slave     bus
);
   localparam int NUM_LEVELS = 2 ** LEVEL_W;
   typedef logic [NUM_LEVELS-1:0] row_t;

   logic [N_LAYERS-1:0]               mask_p1_q, mask_p1_d;
   logic [N_LAYERS-1:0][LEVEL_W-1:0]  lvl_p1_q, lvl_p1_d;
   row_t [NUM_LEVELS-1:0]             contrib_p2;
   row_t [NUM_LEVELS-1:0]             work_q, work_d;
   row_t [NUM_LEVELS-1:0]             snap_q, snap_d;
   logic [31:0]                       frame_count_q, frame_count_d;
   logic [31:0]                       readdata_q, readdata_d;
   logic [31:0]                       rd_mux;
   logic [LEVEL_W-1:0]                rd_idx;
   logic                              frame_ready_q, frame_ready_d;
   logic                              any_coll_q, any_coll_d;
   logic                              irq_en_q, irq_en_d;
   logic                              enable_q, enable_d;
   logic                              unused_bits;

   // Offset/spare fields of each entry and upper write-data bits carry no meaning here.
   assign unused_bits = ^{h_in, bus.writedata};

   // Stage 1: decode active layers and capture their levels.
   always_comb begin
      mask_p1_d = '0;
      lvl_p1_d  = lvl_p1_q;
      for (int k = 0; k < N_LAYERS; k++) begin
         lvl_p1_d[k] = h_in[k*ENTRY_W + ENTRY_W - 1 -: LEVEL_W];
         if (new_pixel && enable_q &&
             (h_in[k*ENTRY_W + ENTRY_W - LEVEL_W - 1 -: ID_W] != '0))
            mask_p1_d[k] = 1'b1;
      end
   end

   // Stage 2: every ordered pair of distinct active layers marks level[j] in row level[i].
   always_comb begin
      contrib_p2 = '0;
      for (int i = 0; i < N_LAYERS; i++) begin
         for (int j = 0; j < N_LAYERS; j++) begin
            if (i != j && mask_p1_q[i] && mask_p1_q[j])
               contrib_p2[lvl_p1_q[i]][lvl_p1_q[j]] = 1'b1;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      rd_idx = LEVEL_W'(bus.address - 8'd4);
      case (bus.address)
         8'd0:    rd_mux = {30'd0, any_coll_q, frame_ready_q};
         8'd1:    rd_mux = {30'd0, enable_q, irq_en_q};
         8'd2:    rd_mux = frame_count_q;
         default: begin
            if (bus.address >= 8'd4 && {1'b0, bus.address} < 9'(4 + NUM_LEVELS))
               rd_mux[NUM_LEVELS-1:0] = snap_q[rd_idx];
         end
      endcase
   end

   always_comb begin
      work_d        = work_q | contrib_p2;
      snap_d        = snap_q;
      frame_count_d = frame_count_q;
      frame_ready_d = frame_ready_q;
      any_coll_d    = any_coll_q;
      irq_en_d      = irq_en_q;
      enable_d      = enable_q;
      readdata_d    = bus.read ? rd_mux : readdata_q;

      if (bus.write && bus.address == 8'd0 && bus.writedata[0])
         frame_ready_d = 1'b0;
      if (bus.write && bus.address == 8'd1) begin
         irq_en_d = bus.writedata[0];
         enable_d = bus.writedata[1];
      end

      // The frame-boundary set overrides a coincident write-1-to-clear.
      if (new_frame) begin
         snap_d        = work_q | contrib_p2;
         work_d        = '0;
         frame_count_d = frame_count_q + 32'd1;
         frame_ready_d = 1'b1;
         any_coll_d    = |snap_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_p1_q     <= '0;
         lvl_p1_q      <= '0;
         work_q        <= '0;
         snap_q        <= '0;
         frame_count_q <= '0;
         readdata_q    <= '0;
         frame_ready_q <= 1'b0;
         any_coll_q    <= 1'b0;
         irq_en_q      <= 1'b0;
         enable_q      <= 1'b1;
      end else begin
         mask_p1_q     <= mask_p1_d;
         lvl_p1_q      <= lvl_p1_d;
         work_q        <= work_d;
         snap_q        <= snap_d;
         frame_count_q <= frame_count_d;
         readdata_q    <= readdata_d;
         frame_ready_q <= frame_ready_d;
         any_coll_q    <= any_coll_d;
         irq_en_q      <= irq_en_d;
         enable_q      <= enable_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = frame_ready_q & any_coll_q & irq_en_q;
endmodule

// File: tb/tb_sprite_collision_matrix.sv
// Directed and randomized bench for sprite_collision_matrix, checked against
// a frame-level behavioural model of the collision rules and register map.
module tb_sprite_collision_matrix;
   localparam int N_LAYERS = 4;
   localparam int LEVEL_W  = 5;
   localparam int ID_W     = 9;
   localparam int ENTRY_W  = LEVEL_W + ID_W + 9;
   localparam int N8       = 8;
   localparam int LW8      = 3;
   localparam int EW8      = LW8 + ID_W + 9;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic new_pixel = 1'b0;
   logic new_frame = 1'b0;
   logic [N_LAYERS*ENTRY_W-1:0] h_in = '0;
   logic new_pixel8 = 1'b0;
   logic new_frame8 = 1'b0;
   logic [N8*EW8-1:0] h_in8 = '0;

   sprite_collision_matrix_if bus ();
   sprite_collision_matrix_if bus8 ();

   sprite_collision_matrix #(.N_LAYERS(N_LAYERS), .LEVEL_W(LEVEL_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n), .new_pixel(new_pixel), .new_frame(new_frame),
      .h_in(h_in), .bus(bus.slave));

   sprite_collision_matrix #(.N_LAYERS(N8), .LEVEL_W(LW8), .ID_W(ID_W)) dut8 (
      .clk(clk), .rst_n(rst_n), .new_pixel(new_pixel8), .new_frame(new_frame8),
      .h_in(h_in8), .bus(bus8.slave));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: whole-frame collision rows and register file.
   logic [31:0] m_work [32];
   logic [31:0] m_snap [32];
   logic [31:0] m_count, m_rd;
   logic        m_fr, m_any, m_irq_en, m_en;
   logic [LEVEL_W-1:0] px_lvl [N_LAYERS];
   logic [ID_W-1:0]    px_id  [N_LAYERS];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_work[r] = '0;
         m_snap[r] = '0;
      end
      m_count = '0; m_rd = '0; m_fr = 1'b0; m_any = 1'b0; m_irq_en = 1'b0; m_en = 1'b1;
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] a);
      if (a == 8'd0) return {30'd0, m_any, m_fr};
      if (a == 8'd1) return {30'd0, m_en, m_irq_en};
      if (a == 8'd2) return m_count;
      if (a >= 8'd4 && a < 8'd36) return m_snap[int'(a) - 4];
      return 32'd0;
   endfunction

   // A pixel belongs to whichever frame is open once this edge's boundary is applied.
   task automatic model_edge();
      logic [31:0] c [32];
      for (int r = 0; r < 32; r++) c[r] = '0;
      if (new_pixel && m_en)
         for (int i = 0; i < N_LAYERS; i++)
            for (int j = 0; j < N_LAYERS; j++)
               if (i != j && px_id[i] != 0 && px_id[j] != 0) c[px_lvl[i]][px_lvl[j]] = 1'b1;
      if (bus.read) m_rd = model_read(bus.address);
      if (bus.write && bus.address == 8'd1) begin
         m_irq_en = bus.writedata[0];
         m_en     = bus.writedata[1];
      end
      if (bus.write && bus.address == 8'd0 && bus.writedata[0]) m_fr = 1'b0;
      if (new_frame) begin
         m_any = 1'b0;
         for (int r = 0; r < 32; r++) begin
            m_snap[r] = m_work[r];
            m_work[r] = '0;
            if (m_snap[r] != 0) m_any = 1'b1;
         end
         m_count = m_count + 32'd1;
         m_fr = 1'b1;
      end
      for (int r = 0; r < 32; r++) m_work[r] = m_work[r] | c[r];
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic pack_px();
      for (int k = 0; k < N_LAYERS; k++)
         h_in[k*ENTRY_W +: ENTRY_W] = {px_lvl[k], px_id[k], 9'($urandom)};
   endtask

   task automatic set_pair(input int l0, input int l1);
      for (int k = 0; k < N_LAYERS; k++) begin
         px_lvl[k] = LEVEL_W'($urandom);
         px_id[k]  = '0;
      end
      px_lvl[0] = LEVEL_W'(l0); px_id[0] = 9'd5;
      px_lvl[1] = LEVEL_W'(l1); px_id[1] = 9'd7;
      pack_px();
   endtask

   task automatic pixel(input logic with_frame);
      new_pixel = 1'b1; new_frame = with_frame;
      tick();
      new_pixel = 1'b0; new_frame = 1'b0;
   endtask

   task automatic frame();
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, input string tag);
      bus.address = a; bus.read = 1'b1;
      tick();
      bus.read = 1'b0;
      chk(tag, bus.readdata, m_rd);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
   endtask

   task automatic chk_irq(input string tag);
      chk(tag, {31'd0, bus.irq}, {31'd0, m_fr & m_any & m_irq_en});
   endtask

   task automatic read8(input int r, output logic [31:0] v);
      bus8.address = 8'(4 + r); bus8.read = 1'b1;
      @(posedge clk); @(negedge clk);
      bus8.read = 1'b0;
      v = bus8.readdata;
   endtask

   function automatic logic [7:0] rule_row8(input int r, input logic [LW8-1:0] lv [N8]);
      logic [7:0] v = '0;
      for (int i = 0; i < N8; i++)
         for (int j = 0; j < N8; j++)
            if (i != j && int'(lv[i]) == r) v[lv[j]] = 1'b1;
      return v;
   endfunction

   logic [31:0] v8;
   logic [LW8-1:0] lv8 [N8];
   logic rd_was;

   initial begin
      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
      bus8.address = '0; bus8.read = 1'b0; bus8.write = 1'b0; bus8.writedata = '0;
      for (int k = 0; k < N_LAYERS; k++) begin px_lvl[k] = '0; px_id[k] = '0; end
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      chk("rst_readdata", bus.readdata, 32'd0);
      chk_irq("rst_irq");
      do_read(8'd0, "rst_status");
      do_read(8'd1, "rst_control");
      chk("rst_control_const", bus.readdata, 32'h2);
      do_read(8'd2, "rst_frame_count");

      // Two layers on levels 10 and 31 mark each other's bit.
      set_pair(10, 31);
      pixel(1'b0);
      frame();
      do_read(8'd14, "row10");
      chk("row10_const", bus.readdata, 32'h8000_0000);
      do_read(8'd35, "row31");
      chk("row31_const", bus.readdata, 32'h0000_0400);
      do_read(8'd0, "status_coll");
      chk("status_coll_const", bus.readdata, 32'h3);

      // A single active layer never collides.
      set_pair(10, 31); px_id[1] = '0; pack_px();
      pixel(1'b0);
      frame();
      for (int r = 0; r < 32; r++) do_read(8'(4 + r), $sformatf("solo_row%0d", r));
      do_read(8'd0, "solo_status");
      chk("solo_status_const", bus.readdata, 32'h1);
      chk_irq("solo_irq");

      // Equal levels set the level's own bit.
      set_pair(6, 6);
      pixel(1'b0);
      frame();
      do_read(8'd10, "same_level_row6");
      chk("same_level_const", bus.readdata, 32'h40);

      // Pixel on the boundary edge goes to the next frame; one edge earlier stays.
      set_pair(3, 5);
      pixel(1'b1);
      do_read(8'd7, "edge_same_now");
      chk("edge_same_now_const", bus.readdata, 32'h0);
      frame();
      do_read(8'd7, "edge_same_next");
      chk("edge_same_next_const", bus.readdata, 32'h20);
      set_pair(1, 2);
      pixel(1'b0);
      frame();
      do_read(8'd5, "edge_before");
      chk("edge_before_const", bus.readdata, 32'h4);

      // Interrupt, write-1-to-clear, and set winning over a coincident clear.
      do_write(8'd1, 32'h3);
      set_pair(7, 9);
      pixel(1'b0);
      frame();
      chk_irq("irq_set");
      chk("irq_set_const", {31'd0, bus.irq}, 32'd1);
      do_write(8'd0, 32'h1);
      chk_irq("irq_clr");
      chk("irq_clr_const", {31'd0, bus.irq}, 32'd0);
      set_pair(7, 9);
      pixel(1'b0);
      bus.address = 8'd0; bus.writedata = 32'h1; bus.write = 1'b1; new_frame = 1'b1;
      tick();
      bus.write = 1'b0; new_frame = 1'b0;
      do_read(8'd0, "set_wins");
      chk("set_wins_const", bus.readdata, 32'h3);
      chk_irq("set_wins_irq");

      // Read and write on the same edge: read returns the old value.
      bus.address = 8'd1; bus.writedata = 32'h0; bus.read = 1'b1; bus.write = 1'b1;
      tick();
      bus.read = 1'b0; bus.write = 1'b0;
      chk("rw_same_edge", bus.readdata, m_rd);
      chk("rw_same_edge_const", bus.readdata, 32'h3);
      chk_irq("irq_disabled");

      // Capture disabled: pixels ignored, frames still counted.
      set_pair(4, 8);
      pixel(1'b0);
      frame();
      do_read(8'd8, "disabled_row4");
      chk("disabled_row4_const", bus.readdata, 32'h0);
      do_read(8'd2, "disabled_count");
      do_write(8'd1, 32'h3);

      // Randomized traffic.
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < N_LAYERS; k++) begin
            px_lvl[k] = LEVEL_W'($urandom_range(0, 31));
            px_id[k]  = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
         end
         pack_px();
         new_pixel = ($urandom_range(0, 9) < 7);
         new_frame = ($urandom_range(0, 19) == 0);
         rd_was = ($urandom_range(0, 2) == 0);
         bus.read = rd_was;
         bus.write = ($urandom_range(0, 24) == 0);
         bus.address = 8'($urandom_range(0, 40));
         bus.writedata = $urandom;
         if (bus.write && $urandom_range(0, 1) == 1) bus.writedata[1] = 1'b1;
         tick();
         if (rd_was) chk($sformatf("rand_rd_a%0d", bus.address), bus.readdata, m_rd);
         chk_irq("rand_irq");
      end
      new_pixel = 1'b0; new_frame = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      frame();
      for (int r = 0; r < 32; r++) do_read(8'(4 + r), $sformatf("rand_row%0d", r));
      do_read(8'd2, "rand_count");
      do_read(8'd3, "reserved");
      do_read(8'd200, "unmapped");

      // Frame counter wrap.
      force dut.frame_count_q = 32'hFFFF_FFFF;
      @(posedge clk); @(negedge clk);
      release dut.frame_count_q;
      m_count = 32'hFFFF_FFFF;
      do_read(8'd2, "count_max");
      frame();
      do_read(8'd2, "count_wrap");
      chk("count_wrap_const", bus.readdata, 32'h0);

      // Asynchronous reset mid-frame discards accumulation.
      do_write(8'd1, 32'h3);
      set_pair(12, 13);
      pixel(1'b0);
      frame();
      do_read(8'd16, "pre_rst_row12");
      set_pair(20, 21);
      pixel(1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_readdata", bus.readdata, 32'h0);
      chk("async_rst_irq", {31'd0, bus.irq}, 32'h0);
      model_reset();
      #1 rst_n = 1'b1;
      do_read(8'd16, "post_rst_row12");
      do_read(8'd1, "post_rst_control");
      frame();
      do_read(8'd2, "post_rst_count");
      chk("post_rst_count_const", bus.readdata, 32'h1);
      do_read(8'd24, "post_rst_row20");

      // Eight layers, three-bit levels.
      for (int k = 0; k < N8; k++) begin
         lv8[k] = LW8'(k);
         h_in8[k*EW8 +: EW8] = {LW8'(k), 9'(k + 1), 9'($urandom)};
      end
      new_pixel8 = 1'b1;
      @(posedge clk); @(negedge clk);
      new_pixel8 = 1'b0; new_frame8 = 1'b1;
      @(posedge clk); @(negedge clk);
      new_frame8 = 1'b0;
      for (int r = 0; r < N8; r++) begin
         read8(r, v8);
         chk($sformatf("sweep_row%0d", r), v8, 32'h00FF & ~(32'd1 << r));
      end
      lv8[7] = '0;
      h_in8[7*EW8 +: EW8] = {LW8'(0), 9'd99, 9'd0};
      new_pixel8 = 1'b1;
      @(posedge clk); @(negedge clk);
      new_pixel8 = 1'b0; new_frame8 = 1'b1;
      @(posedge clk); @(negedge clk);
      new_frame8 = 1'b0;
      for (int r = 0; r < N8; r++) begin
         read8(r, v8);
         chk($sformatf("sweep_dup_row%0d", r), v8, {24'd0, rule_row8(r, lv8)});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
